// File: rtl/scale_pkg.sv
// scale_pkg: size/clamp constants, saturating step helpers and frame-buffer address helper
package scale_pkg;
   localparam int DIM_W = 12;
   typedef logic [DIM_W-1:0] dim_t;
   localparam dim_t STEP_S = 10;
   localparam dim_t STEP_L = 100;
   localparam dim_t W_MIN = 64;
   localparam dim_t W_MAX = 1920;
   localparam dim_t H_MIN = 36;
   localparam dim_t H_MAX = 1080;
   localparam dim_t W_INIT = 640;
   localparam dim_t H_INIT = 320;
   localparam dim_t SRC_W = 1280;
   localparam dim_t SRC_H = 720;
   localparam logic [31:0] DEF_BUF_BASE = 32'h0100000;
   localparam logic [31:0] DEF_BUF_STRIDE = 32'h0400000;

   // One extra bit of headroom so the sum can never wrap before clamping
   function automatic dim_t clamp_add(input dim_t v, input dim_t step, input dim_t mx);
      logic [DIM_W:0] s;
      s = {1'b0, v} + {1'b0, step};
      return (s > {1'b0, mx}) ? mx : s[DIM_W-1:0];
   endfunction

   function automatic dim_t clamp_sub(input dim_t v, input dim_t step, input dim_t mn);
      return ({1'b0, v} < {1'b0, mn} + {1'b0, step}) ? mn : v - step;
   endfunction

   function automatic logic [31:0] idx_to_addr(input logic [2:0] idx, input logic [31:0] base,
                                               input logic [31:0] stride);
      return base + {29'd0, idx} * stride;
   endfunction
endpackage

// File: rtl/scale_size_ctrl_sync_edge.sv
// sync_edge: 2-FF synchroniser with a registered rising-edge pulse
module sync_edge (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic lvl,
   output logic rise
);
   logic s1;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         s1   <= 1'b0;
         lvl  <= 1'b0;
         rise <= 1'b0;
      end else begin
         s1   <= d;
         lvl  <= s1;
         rise <= s1 & ~lvl;
      end
endmodule

// File: rtl/scale_size_ctrl.sv
// scale_size_ctrl: key-driven target size with frame-boundary commit and DDR frame-buffer ring control
module scale_size_ctrl
   import scale_pkg::*;
#(
   parameter int          ADDR_W     = 28,
   parameter int          NUM_BUF    = 4,
   parameter int          RD_LAG     = 2,
   parameter logic [31:0] BUF_BASE   = DEF_BUF_BASE,
   parameter logic [31:0] BUF_STRIDE = DEF_BUF_STRIDE
) (
   input  logic              axi_clk,
   input  logic              rst,
   input  logic [3:0]        key_i,
   input  logic              axis_sel_i,
   input  logic              vs_i,
   input  logic              wr_frame_done_i,
   output logic [DIM_W-1:0]  tgt_width_o,
   output logic [DIM_W-1:0]  tgt_height_o,
   output logic              param_upd_o,
   output logic              is_720p_o,
   output logic [2:0]        wr_index_o,
   output logic [ADDR_W-1:0] write_addr_o,
   output logic [ADDR_W-1:0] read_addr_o,
   output logic [15:0]       drop_cnt_o
);
   localparam logic INIT_720 = (W_INIT <= SRC_W) && (H_INIT <= SRC_H);
   localparam logic [31:0] RA0 = idx_to_addr(3'((NUM_BUF - RD_LAG) % NUM_BUF), BUF_BASE, BUF_STRIDE);

   logic [5:0] raw, lvl, rise;
   logic [3:0] kp;
   logic sel, vs_pos, unused;
   assign raw = {vs_i, axis_sel_i, key_i};
   for (genvar g = 0; g < 6; g++) begin : g_sync
      sync_edge u_sync (.clk(axi_clk), .rst(rst), .d(raw[g]), .lvl(lvl[g]), .rise(rise[g]));
   end
   assign kp = rise[3:0];
   assign sel = lvl[4];
   assign vs_pos = rise[5];
   assign unused = ^{lvl[5], lvl[3:0]};

   dim_t pend_w, pend_h, cur, nxt, mx, mn;
   // Highest-priority edge wins; the rest of that cycle's edges are dropped
   always_comb begin
      cur = sel ? pend_w : pend_h;
      mx  = sel ? W_MAX : H_MAX;
      mn  = sel ? W_MIN : H_MIN;
      nxt = kp[0] ? clamp_add(cur, STEP_S, mx) :
            kp[1] ? clamp_sub(cur, STEP_S, mn) :
            kp[2] ? clamp_add(cur, STEP_L, mx) : clamp_sub(cur, STEP_L, mn);
   end

   always_ff @(posedge axi_clk or posedge rst)
      if (rst) begin
         pend_w <= W_INIT;
         pend_h <= H_INIT;
      end else if (|kp) begin
         if (sel) pend_w <= nxt;
         else     pend_h <= nxt;
      end

   always_ff @(posedge axi_clk or posedge rst)
      if (rst) begin
         tgt_width_o  <= W_INIT;
         tgt_height_o <= H_INIT;
         is_720p_o    <= INIT_720;
         param_upd_o  <= 1'b0;
      end else begin
         param_upd_o <= vs_pos && (pend_w != tgt_width_o || pend_h != tgt_height_o);
         if (vs_pos) begin
            tgt_width_o  <= pend_w;
            tgt_height_o <= pend_h;
            is_720p_o    <= (pend_w <= SRC_W) && (pend_h <= SRC_H);
         end
      end

   logic done_flag;
   // A frame boundary without a finished write reuses the same buffer
   always_ff @(posedge axi_clk or posedge rst)
      if (rst) begin
         wr_index_o <= 3'd0;
         done_flag  <= 1'b1;
         drop_cnt_o <= 16'd0;
      end else if (vs_pos) begin
         done_flag <= 1'b0;
         if (done_flag || wr_frame_done_i)
            wr_index_o <= (wr_index_o == 3'(NUM_BUF - 1)) ? 3'd0 : wr_index_o + 3'd1;
         else if (drop_cnt_o != 16'hFFFF)
            drop_cnt_o <= drop_cnt_o + 16'd1;
      end else if (wr_frame_done_i) begin
         done_flag <= 1'b1;
      end

   logic [3:0] rsum;
   logic [2:0] rd_index;
   assign rsum = {1'b0, wr_index_o} + 4'(NUM_BUF - RD_LAG);
   assign rd_index = (rsum >= 4'(NUM_BUF)) ? 3'(rsum - 4'(NUM_BUF)) : rsum[2:0];

   always_ff @(posedge axi_clk or posedge rst)
      if (rst) begin
         write_addr_o <= ADDR_W'(BUF_BASE);
         read_addr_o  <= ADDR_W'(RA0);
      end else begin
         write_addr_o <= ADDR_W'(idx_to_addr(wr_index_o, BUF_BASE, BUF_STRIDE));
         read_addr_o  <= ADDR_W'(idx_to_addr(rd_index, BUF_BASE, BUF_STRIDE));
      end
endmodule

// File: tb/tb_scale_size_ctrl.sv
// tb_scale_size_ctrl: directed checks of size stepping/commit and frame-buffer ring behaviour
module tb_scale_size_ctrl;
   logic axi_clk = 1'b0;
   logic rst = 1'b1;
   logic [3:0] key = 4'd0;
   logic axis_sel = 1'b0;
   logic vs = 1'b0;
   logic wr_frame_done = 1'b0;
   logic [11:0] tgt_width, tgt_height;
   logic param_upd, is_720p;
   logic [2:0] wr_index;
   logic [27:0] write_addr, read_addr;
   logic [15:0] drop_cnt;
   int total = 0;
   int passed = 0;
   int upd_cnt = 0;
   int upd_snap;

   scale_size_ctrl dut (
      .axi_clk(axi_clk), .rst(rst), .key_i(key), .axis_sel_i(axis_sel), .vs_i(vs),
      .wr_frame_done_i(wr_frame_done), .tgt_width_o(tgt_width), .tgt_height_o(tgt_height),
      .param_upd_o(param_upd), .is_720p_o(is_720p), .wr_index_o(wr_index),
      .write_addr_o(write_addr), .read_addr_o(read_addr), .drop_cnt_o(drop_cnt)
   );

   always #5 axi_clk = ~axi_clk;
   always @(posedge axi_clk) if (param_upd) upd_cnt <= upd_cnt + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) $display("FAIL %s got=%0d (0x%0h) exp=%0d (0x%0h)", tag, got, got, exp, exp);
      else passed++;
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge axi_clk);
   endtask

   task automatic press(input int k);
      key[k] = 1'b1;
      tick(4);
      key = 4'd0;
      tick(4);
   endtask

   task automatic presses(input int k, input int n);
      repeat (n) press(k);
   endtask

   task automatic frame(input logic done);
      if (done) begin
         wr_frame_done = 1'b1;
         tick(1);
         wr_frame_done = 1'b0;
      end
      vs = 1'b1;
      tick(4);
      vs = 1'b0;
      tick(4);
   endtask

   task automatic do_reset();
      key = 4'd0;
      vs = 1'b0;
      wr_frame_done = 1'b0;
      rst = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(2);
   endtask

   function automatic logic [31:0] addr(input int i);
      return 32'h0100000 + i * 32'h0400000;
   endfunction

   task automatic chk_ring(input string tag, input int idx, input int drops);
      chk({tag, "_idx"}, 32'(wr_index), idx);
      chk({tag, "_waddr"}, 32'(write_addr), addr(idx));
      chk({tag, "_raddr"}, 32'(read_addr), addr((idx + 2) % 4));
      chk({tag, "_drop"}, 32'(drop_cnt), drops);
   endtask

   initial begin
      bit seen;
      int exp_idx[4] = '{1, 2, 3, 0};
      do_reset();
      chk("rst_w", 32'(tgt_width), 640);
      chk("rst_h", 32'(tgt_height), 320);
      chk("rst_720", 32'(is_720p), 1);
      chk("rst_upd", 32'(param_upd), 0);
      chk_ring("rst", 0, 0);

      axis_sel = 1'b1;
      tick(4);
      upd_snap = upd_cnt;
      presses(2, 6);
      chk("pend_not_commit", 32'(tgt_width), 640);
      frame(1);
      chk("w1240", 32'(tgt_width), 1240);
      chk("w1240_720", 32'(is_720p), 1);
      chk("w1240_upd", 32'(upd_cnt - upd_snap), 1);
      chk("w1240_h", 32'(tgt_height), 320);
      press(2);
      frame(1);
      chk("w1340", 32'(tgt_width), 1340);
      chk("w1340_720", 32'(is_720p), 0);
      chk("w1340_upd", 32'(upd_cnt - upd_snap), 2);

      do_reset();
      axis_sel = 1'b1;
      tick(4);
      presses(3, 5);
      presses(1, 7);
      frame(1);
      chk("w70", 32'(tgt_width), 70);
      press(3);
      frame(1);
      chk("w_min_clamp", 32'(tgt_width), 64);
      upd_snap = upd_cnt;
      press(1);
      frame(1);
      chk("w_min_hold", 32'(tgt_width), 64);
      chk("no_upd_same", 32'(upd_cnt - upd_snap), 0);
      axis_sel = 1'b0;
      tick(4);
      presses(2, 7);
      presses(0, 5);
      frame(1);
      chk("h1070", 32'(tgt_height), 1070);
      press(2);
      press(0);
      frame(1);
      chk("h_max_clamp", 32'(tgt_height), 1080);
      chk("h1080_w", 32'(tgt_width), 64);
      chk("h1080_720", 32'(is_720p), 0);

      axis_sel = 1'b1;
      tick(4);
      key = 4'b1001;
      tick(4);
      key = 4'd0;
      tick(4);
      frame(1);
      chk("prio_s_over_l", 32'(tgt_width), 74);

      upd_snap = upd_cnt;
      key[0] = 1'b1;
      vs = 1'b1;
      tick(4);
      key = 4'd0;
      vs = 1'b0;
      tick(4);
      chk("key_vs_old", 32'(tgt_width), 74);
      chk("key_vs_noupd", 32'(upd_cnt - upd_snap), 0);
      frame(1);
      chk("key_vs_next", 32'(tgt_width), 84);
      chk("key_vs_upd", 32'(upd_cnt - upd_snap), 1);

      do_reset();
      for (int i = 0; i < 4; i++) begin
         frame(1);
         chk_ring($sformatf("ring%0d", i), exp_idx[i], 0);
      end
      frame(0);
      chk_ring("drop", 0, 1);
      seen = 1'b0;
      vs = 1'b1;
      for (int i = 0; i < 10 && !seen; i++) begin
         tick(1);
         seen = dut.vs_pos;
      end
      chk("vs_pos_wait", 32'(seen), 1);
      wr_frame_done = 1'b1;
      tick(1);
      wr_frame_done = 1'b0;
      tick(3);
      vs = 1'b0;
      tick(4);
      chk_ring("coinc", 1, 1);

      do_reset();
      frame(1);
      frame(0);
      chk_ring("pre_rst", 1, 1);
      axis_sel = 1'b1;
      tick(4);
      presses(2, 2);
      presses(0, 6);
      axis_sel = 1'b0;
      tick(4);
      press(2);
      presses(0, 8);
      chk("pend_900_w", 32'(tgt_width), 640);
      upd_snap = upd_cnt;
      #2 rst = 1'b1;
      #1;
      chk("async_w", 32'(tgt_width), 640);
      chk("async_h", 32'(tgt_height), 320);
      chk("async_720", 32'(is_720p), 1);
      chk("async_upd", 32'(param_upd), 0);
      chk_ring("async", 0, 0);
      tick(3);
      rst = 1'b0;
      tick(2);
      frame(1);
      chk("post_rst_w", 32'(tgt_width), 640);
      chk("post_rst_h", 32'(tgt_height), 320);
      chk("post_rst_upd", 32'(upd_cnt - upd_snap), 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end
endmodule
